// File: rtl/sn74ls490_gate_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : gate_ctrl_pkg
// Brief   : Shared state encoding and BCD constants for the gate controller.
// Rev     : 1.0  initial release
// ============================================================================
package gate_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_GATE  = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    localparam int          BCD_W    = 4;
    localparam logic [3:0]  BCD_NINE = 4'd9;

endpackage
`default_nettype wire

// File: rtl/sn74ls490_gate_ctrl_bcd_digit.sv
`default_nettype none
// ============================================================================
// Module  : bcd_digit
// Brief   : One synchronous decade; wraps 9 -> 0 and flags the nine state.
// Rev     : 1.0  initial release
// ============================================================================
module bcd_digit (
    input  logic       clk,
    input  logic       clr,
    input  logic       zero,
    input  logic       inc,
    output logic [3:0] q,
    output logic       nine
);
    import gate_ctrl_pkg::*;

    logic [BCD_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_q <= '0;
        end else if (zero) begin
            r_q <= '0;
        end else if (inc) begin
            r_q <= nine ? '0 : r_q + 1'b1;
        end
    end

    assign nine = (r_q == BCD_NINE);
    assign q    = r_q;

endmodule
`default_nettype wire

// File: rtl/sn74ls490_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sn74ls490_gate_ctrl
// Brief   : Clear -> gate -> latch sequencer for a decade-counter cascade with
//           an internal BCD image. Optional macro SN74LS490_GATE_LOAD_EN adds
//           a run-time window length input (gate_len).
// Rev     : 1.0  initial release
// ============================================================================
module sn74ls490_gate_ctrl #(
    parameter int DIGITS      = 4,
    parameter int GATE_CYCLES = 1000,
    parameter int GATE_W      = 16
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  start,
    input  logic                  continuous,
    input  logic                  evt,
`ifdef SN74LS490_GATE_LOAD_EN
    input  logic [GATE_W-1:0]     gate_len,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   result,
    output logic                  cnt_clr,
    output logic                  cnt_en
);
    import gate_ctrl_pkg::*;

    localparam logic [GATE_W-1:0] c_gate_load = GATE_W'(GATE_CYCLES - 1);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [GATE_W-1:0]         r_gate_cnt;
    logic [GATE_W-1:0]         w_gate_load;
    logic                      r_evt_s1;
    logic                      r_evt_s2;
    logic                      r_evt_d;
    logic                      w_rise;
    logic                      w_zero;
    logic [DIGITS:0]           w_carry;
    logic [DIGITS-1:0]         w_nine;
    logic [BCD_W*DIGITS-1:0]   w_digits;
    logic                      r_ovf;
    logic                      r_overflow;
    logic [BCD_W*DIGITS-1:0]   r_result;

`ifdef SN74LS490_GATE_LOAD_EN
    // A zero length would never terminate cleanly; run it as a single cycle.
    assign w_gate_load = (gate_len == '0) ? '0 : gate_len - 1'b1;
`else
    assign w_gate_load = c_gate_load;
`endif

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_evt_s1 <= 1'b0;
            r_evt_s2 <= 1'b0;
            r_evt_d  <= 1'b0;
        end else begin
            r_evt_s1 <= evt;
            r_evt_s2 <= r_evt_s1;
            r_evt_d  <= r_evt_s2;
        end
    end

    assign w_rise     = r_evt_s2 & ~r_evt_d;
    assign w_carry[0] = w_rise & (r_state == ST_GATE);

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_gate_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_gate_cnt <= w_gate_load;
        end else if ((r_state == ST_GATE) && (r_gate_cnt != '0)) begin
            r_gate_cnt <= r_gate_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        done        = 1'b0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        w_zero      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy    = 1'b0;
                cnt_clr = 1'b1;
                if (start) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_clr     = 1'b1;
                w_zero      = 1'b1;
                w_state_nxt = ST_GATE;
            end
            ST_GATE: begin
                cnt_en = 1'b1;
                if (r_gate_cnt == '0) begin
                    w_state_nxt = ST_LATCH;
                end
            end
            ST_LATCH: begin
                done        = 1'b1;
                w_state_nxt = continuous ? ST_CLEAR : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Ripple-free carry: a decade steps only when every lower decade sits at 9.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        bcd_digit u_digit (
            .clk  (clk),
            .clr  (clr),
            .zero (w_zero),
            .inc  (w_carry[gi]),
            .q    (w_digits[gi*BCD_W +: BCD_W]),
            .nine (w_nine[gi])
        );
        assign w_carry[gi+1] = w_carry[gi] & w_nine[gi];
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_ovf      <= 1'b0;
            r_overflow <= 1'b0;
            r_result   <= '0;
        end else begin
            if (w_zero) begin
                r_ovf <= 1'b0;
            end else if (w_carry[DIGITS]) begin
                r_ovf <= 1'b1;
            end
            if (r_state == ST_LATCH) begin
                r_result   <= w_digits;
                r_overflow <= r_ovf;
            end
        end
    end

    assign result   = r_result;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_sn74ls490_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_sn74ls490_gate_ctrl
// Brief   : Directed self-checking bench for the gate-time controller.
// Rev     : 1.0  initial release
// ============================================================================
module tb_sn74ls490_gate_ctrl;

    logic clk = 1'b0;
    logic clr;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Instance a: DIGITS=4, 100-cycle window
    logic        a_start, a_cont, a_evt;
    logic        a_busy, a_done, a_ovf, a_cnt_clr, a_cnt_en;
    logic [15:0] a_result;
    // Instance c: DIGITS=4, 2000-cycle window
    logic        c_start, c_cont, c_evt;
    logic        c_busy, c_done, c_ovf, c_cnt_clr, c_cnt_en;
    logic [15:0] c_result;
    // Instance o: DIGITS=2, 400-cycle window
    logic        o_start, o_cont, o_evt;
    logic        o_busy, o_done, o_ovf, o_cnt_clr, o_cnt_en;
    logic [7:0]  o_result;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sn74ls490_gate_ctrl #(.DIGITS(4), .GATE_CYCLES(100), .GATE_W(16)) dut_a (
        .clk(clk), .clr(clr), .start(a_start), .continuous(a_cont), .evt(a_evt),
`ifdef SN74LS490_GATE_LOAD_EN
        .gate_len(16'd100),
`endif
        .busy(a_busy), .done(a_done), .overflow(a_ovf), .result(a_result),
        .cnt_clr(a_cnt_clr), .cnt_en(a_cnt_en)
    );

    sn74ls490_gate_ctrl #(.DIGITS(4), .GATE_CYCLES(2000), .GATE_W(16)) dut_c (
        .clk(clk), .clr(clr), .start(c_start), .continuous(c_cont), .evt(c_evt),
`ifdef SN74LS490_GATE_LOAD_EN
        .gate_len(16'd2000),
`endif
        .busy(c_busy), .done(c_done), .overflow(c_ovf), .result(c_result),
        .cnt_clr(c_cnt_clr), .cnt_en(c_cnt_en)
    );

    sn74ls490_gate_ctrl #(.DIGITS(2), .GATE_CYCLES(400), .GATE_W(16)) dut_o (
        .clk(clk), .clr(clr), .start(o_start), .continuous(o_cont), .evt(o_evt),
`ifdef SN74LS490_GATE_LOAD_EN
        .gate_len(16'd400),
`endif
        .busy(o_busy), .done(o_done), .overflow(o_ovf), .result(o_result),
        .cnt_clr(o_cnt_clr), .cnt_en(o_cnt_en)
    );

    task automatic test_reset();
        clr = 1'b0;
        a_start = 0; a_cont = 0; a_evt = 0;
        c_start = 0; c_cont = 0; c_evt = 0;
        o_start = 0; o_cont = 0; o_evt = 0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (a_result !== 16'h0000) begin
            n_fail++; $display("FAIL reset_result: got %h expected %h", a_result, 16'h0000);
        end
        n_checks++;
        if ({a_busy, a_done, a_ovf, a_cnt_clr, a_cnt_en} !== 5'b00010) begin
            n_fail++;
            $display("FAIL reset_flags: got busy/done/ovf/clr/en=%b expected %b",
                     {a_busy, a_done, a_ovf, a_cnt_clr, a_cnt_en}, 5'b00010);
        end
        n_checks++;
        if ({c_result, o_result, c_busy, o_busy, c_ovf, o_ovf} !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_others: got %h expected %h",
                     {c_result, o_result, c_busy, o_busy, c_ovf, o_ovf}, 28'h0);
        end
        clr = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_count();
        int st;
        int n;
        a_start = 1; st = cyc;
        @(negedge clk);
        a_start = 0;
        n_checks++;
        if ({a_busy, a_cnt_clr, a_cnt_en} !== 3'b110) begin
            n_fail++; $display("FAIL basic_clear_phase: got %b expected %b", {a_busy, a_cnt_clr, a_cnt_en}, 3'b110);
        end
        @(negedge clk);
        n_checks++;
        if ({a_cnt_clr, a_cnt_en} !== 2'b01) begin
            n_fail++; $display("FAIL basic_gate_phase: got %b expected %b", {a_cnt_clr, a_cnt_en}, 2'b01);
        end
        for (int k = 0; k < 10; k++) begin
            a_evt = 1; @(negedge clk);
            a_evt = 0; repeat (9) @(negedge clk);
            if (k == 5) begin
                n_checks++;
                if (a_result !== 16'h0000) begin
                    n_fail++; $display("FAIL basic_result_stable: got %h expected %h", a_result, 16'h0000);
                end
            end
        end
        n = 0;
        while (!a_done && n < 300) begin @(negedge clk); n++; end
        n_checks++;
        if (cyc !== st + 102) begin
            n_fail++; $display("FAIL basic_done_time: got cycle %0d expected %0d", cyc, st + 102);
        end
        @(negedge clk);
        n_checks++;
        if ({a_result, a_ovf, a_busy, a_done} !== {16'h0010, 3'b000}) begin
            n_fail++;
            $display("FAIL basic_result: got result=%h ovf/busy/done=%b expected result=0010 ovf/busy/done=000",
                     a_result, {a_ovf, a_busy, a_done});
        end
    endtask

    task automatic test_continuous();
        int st;
        int n;
        int nd;
        int drops;
        int dt[3];
        a_cont = 1; a_start = 1; st = cyc;
        @(negedge clk);
        a_start = 0;
        nd = 0; drops = 0; n = 0;
        dt[0] = 0; dt[1] = 0; dt[2] = 0;
        while (nd < 3 && n < 1000) begin
            if (nd == 2 && !a_done) a_cont = 0;
            if (!a_busy) drops++;
            if (a_done) begin dt[nd] = cyc; nd++; end
            @(negedge clk); n++;
        end
        n_checks++;
        if (nd != 3) begin
            n_fail++; $display("FAIL cont_done_count: got %0d expected %0d", nd, 3);
        end
        n_checks++;
        if (dt[0] - st != 102 || dt[1] - dt[0] != 102 || dt[2] - dt[1] != 102) begin
            n_fail++;
            $display("FAIL cont_spacing: got %0d/%0d/%0d expected 102/102/102",
                     dt[0] - st, dt[1] - dt[0], dt[2] - dt[1]);
        end
        n_checks++;
        if (drops != 0) begin
            n_fail++; $display("FAIL cont_busy_drop: got %0d idle samples expected %0d", drops, 0);
        end
        n_checks++;
        if ({a_busy, a_result} !== {1'b0, 16'h0000}) begin
            n_fail++; $display("FAIL cont_end: got busy=%b result=%h expected busy=0 result=0000", a_busy, a_result);
        end
    endtask

    task automatic test_start_ignored();
        int st;
        int n;
        a_cont = 1; a_start = 1; st = cyc;
        @(negedge clk);
        a_start = 0;
        @(negedge clk);
        a_start = 1; a_cont = 0;
        for (int k = 0; k < 3; k++) begin
            a_evt = 1; @(negedge clk);
            a_evt = 0; repeat (9) @(negedge clk);
        end
        a_start = 0;
        n = 0;
        while (!a_done && n < 300) begin @(negedge clk); n++; end
        n_checks++;
        if (cyc !== st + 102) begin
            n_fail++; $display("FAIL ign_done_time: got cycle %0d expected %0d", cyc, st + 102);
        end
        @(negedge clk);
        n_checks++;
        if ({a_busy, a_result} !== {1'b0, 16'h0003}) begin
            n_fail++; $display("FAIL ign_result: got busy=%b result=%h expected busy=0 result=0003", a_busy, a_result);
        end
    endtask

    task automatic test_carry();
        int st;
        int n;
        for (int k = 0; k < 10; k++) begin c_evt = ~c_evt; @(negedge clk); end
        c_start = 1; st = cyc;
        c_evt = ~c_evt; @(negedge clk);
        c_start = 0;
        n = 0;
        while (!c_done && n < 2500) begin c_evt = ~c_evt; @(negedge clk); n++; end
        n_checks++;
        if (cyc !== st + 2002) begin
            n_fail++; $display("FAIL carry_done_time: got cycle %0d expected %0d", cyc, st + 2002);
        end
        @(negedge clk);
        c_evt = 0;
        n_checks++;
        if ({c_result, c_ovf} !== {16'h1000, 1'b0}) begin
            n_fail++; $display("FAIL carry_result: got %h ovf=%b expected 1000 ovf=0", c_result, c_ovf);
        end
    endtask

    task automatic test_overflow();
        int n;
        for (int w = 0; w < 2; w++) begin
            o_start = 1;
            @(negedge clk);
            o_start = 0;
            @(negedge clk);
            for (int k = 0; k < ((w == 0) ? 150 : 5); k++) begin
                o_evt = 1; @(negedge clk);
                o_evt = 0; @(negedge clk);
            end
            if (w == 1) begin
                n_checks++;
                if ({o_result, o_ovf} !== {8'h50, 1'b1}) begin
                    n_fail++; $display("FAIL ovf_stable: got %h ovf=%b expected 50 ovf=1", o_result, o_ovf);
                end
            end
            n = 0;
            while (!o_done && n < 600) begin @(negedge clk); n++; end
            n_checks++;
            if (o_done !== 1'b1) begin
                n_fail++; $display("FAIL ovf_done_timeout: got done=%b expected 1", o_done);
            end
            @(negedge clk);
            n_checks++;
            if (w == 0 && {o_result, o_ovf} !== {8'h50, 1'b1}) begin
                n_fail++; $display("FAIL ovf_first: got %h ovf=%b expected 50 ovf=1", o_result, o_ovf);
            end else if (w == 1 && {o_result, o_ovf} !== {8'h05, 1'b0}) begin
                n_fail++; $display("FAIL ovf_second: got %h ovf=%b expected 05 ovf=0", o_result, o_ovf);
            end
        end
    endtask

    task automatic test_abort();
        int seen;
        a_start = 1;
        @(negedge clk);
        a_start = 0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            a_evt = 1; @(negedge clk);
            a_evt = 0; repeat (4) @(negedge clk);
        end
        clr = 0;
        @(negedge clk);
        clr = 1;
        n_checks++;
        if ({a_busy, a_done, a_ovf, a_cnt_clr, a_cnt_en, a_result} !== {5'b00010, 16'h0000}) begin
            n_fail++;
            $display("FAIL abort_state: got flags=%b result=%h expected flags=00010 result=0000",
                     {a_busy, a_done, a_ovf, a_cnt_clr, a_cnt_en}, a_result);
        end
        seen = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (a_done || a_busy) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++; $display("FAIL abort_no_done: got %0d active cycles expected %0d", seen, 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_count();
        test_continuous();
        test_start_ignored();
        test_carry();
        test_overflow();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
